sram_ctrl: RTL

- Synchronous controller between an on-chip req/ready request port and the DE2 512 KB async SRAM (IS61LV25616, 256K x 16).
- Replaces tying the SRAM controls low: all SRAM control, address and data-out pins are registered, and write pulses are timed.
- Instantiated under the lab top level. The top-level wrapper implements the tristate: SRAM_DQ = dq_oe ? dq_out : 16'bZ, and dq_in = SRAM_DQ.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared encodings and widths for the DE2 async SRAM controller.
package sram_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  // The counter counts down to zero, so an N-cycle phase starts at N-1.
  function automatic logic [3:0] cnt_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Request-port to IS61LV25616 async SRAM controller; every SRAM-facing pin is
// registered and the write strobe is timed by a down-counter.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam logic [3:0] RD_LOAD = cnt_load(RD_CYCLES);
  localparam logic [3:0] WE_LOAD = cnt_load(WE_CYCLES);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] dout_next, rdata_next;
  logic              ub_n_next, lb_n_next, rvalid_next;
  logic              ce_n_next, oe_n_next, we_n_next, oe_drive_next;

  assign ready = (state == IDLE) && !Reset;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    addr_next   = SRAM_ADDR;
    dout_next   = dq_out;
    ub_n_next   = SRAM_UB_N;
    lb_n_next   = SRAM_LB_N;
    rdata_next  = rdata;
    rvalid_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          addr_next  = addr;
          dout_next  = wdata;
          ub_n_next  = ~be[1];
          lb_n_next  = ~be[0];
          state_next = we ? WR_SETUP : RD;
          cnt_next   = we ? WE_LOAD : RD_LOAD;
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          rdata_next  = dq_in;
          rvalid_next = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: begin
        if (cnt == 4'd0) state_next = WR_HOLD;
        else             cnt_next   = cnt - 4'd1;
      end
      WR_HOLD:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control pins are decoded from the state being entered so they land in
  // their registers on the same edge as the state change; OE and the data
  // driver are owned by disjoint states, which keeps the bus free of contention.
  always_comb begin
    ce_n_next     = (state_next == IDLE);
    oe_n_next     = (state_next != RD);
    we_n_next     = (state_next != WR_PULSE);
    oe_drive_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                    (state_next == WR_HOLD);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      SRAM_ADDR <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      SRAM_ADDR <= addr_next;
      dq_out    <= dout_next;
      dq_oe     <= oe_drive_next;
      SRAM_CE_N <= ce_n_next;
      SRAM_OE_N <= oe_n_next;
      SRAM_WE_N <= we_n_next;
      SRAM_UB_N <= ub_n_next;
      SRAM_LB_N <= lb_n_next;
      rdata     <= rdata_next;
      rvalid    <= rvalid_next;
    end
  end

endmodule
